// File: rtl/copperv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : copperv_pkg
// Purpose : Shared constants, types and helpers for the copperv core.
//           INSTR_BYTES      - size of one instruction word in bytes
//           RESET_PC_DEFAULT - default fetch address out of reset
//           word_align()     - clears the two byte-offset bits of an address
// Revision: 1.0 - initial release
// ============================================================================
package copperv_pkg;

   localparam int unsigned INSTR_BYTES      = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] word_t;

   function automatic addr_t word_align(input addr_t a);
      return a & ~32'h0000_0003;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Purpose : Single-clock FIFO with flush. Simultaneous push and pop is legal
//           at any occupancy, including full. Flush empties the FIFO and
//           overrides any push/pop in the same cycle.
// Ports   : clk, rstn    - clock, synchronous active-low reset
//           push_i/wdata_i - write request and data
//           pop_i        - read request (removes head)
//           flush_i      - discard all entries
//           rdata_o      - head entry (undefined when empty)
//           full_o, empty_o, count_o - occupancy status
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [c_PTR_W-1:0] wr_ptr_q;
   logic [c_PTR_W-1:0] rd_ptr_q;
   logic [c_CNT_W-1:0] count_q;
   logic               do_push;
   logic               do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == c_CNT_W'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A pop frees the head slot in the same edge, so a full FIFO may still
   // accept a push when it is also being popped.
   assign do_pop  = pop_i && !empty_o && !flush_i;
   assign do_push = push_i && !flush_i && (!full_o || pop_i);

   always_ff @(posedge clk) begin
      if (!rstn || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
         count_q <= count_q + c_CNT_W'(do_push) - c_CNT_W'(do_pop);
      end
   end

   // Storage needs no reset: entries are only observed when count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Purpose : Instruction fetch stage. Holds the PC, issues word-aligned reads
//           on the instruction bus under a credit scheme that guarantees a
//           buffer slot for every kept response, buffers returned words and
//           hands them to the execution unit over valid/ready. A redirect
//           loads a new PC and discards buffered and in-flight instructions.
// Ports   : clk, rstn                  - clock, synchronous active-low reset
//           instr, instr_valid, instr_ready - instruction output handshake
//           redirect_valid, redirect_pc - PC redirect request
//           ibus_cmd_addr/en/ready      - bus read command channel
//           ibus_rsp_rdata/valid        - bus read response channel
// Revision: 1.0 - initial release
// ============================================================================
module fetch_unit
   import copperv_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rstn,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] ibus_cmd_addr,
   output logic        ibus_cmd_en,
   input  logic        ibus_cmd_ready,
   input  logic [31:0] ibus_rsp_rdata,
   input  logic        ibus_rsp_valid
);

   localparam int                 c_CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [c_CNT_W-1:0] c_MAX_OUT = c_CNT_W'(MAX_OUTSTANDING);
   localparam logic [c_CNT_W:0]   c_DEPTH   = (c_CNT_W + 1)'(FIFO_DEPTH);

   logic [31:0]        pc_q, pc_d;
   logic [c_CNT_W-1:0] out_q, out_d;          // accepted, unanswered reads
   logic [c_CNT_W-1:0] discard_q, discard_d;  // in-flight reads to drop
   logic [c_CNT_W-1:0] fifo_count;
   logic [31:0]        fifo_rdata;
   logic               fifo_empty;
   logic               fifo_full;
   logic               rsp_ok;
   logic               accept;
   logic               push;
   logic               pop;

   // Responses with nothing outstanding are protocol violations; ignore them.
   assign rsp_ok = ibus_rsp_valid && (out_q != '0);

   // Credit check uses only registered state, so neither instr_ready nor the
   // response channel reaches ibus_cmd_en combinationally.
   assign ibus_cmd_en   = rstn && !redirect_valid && (out_q < c_MAX_OUT) &&
                          (({1'b0, fifo_count} + {1'b0, out_q}) < c_DEPTH);
   assign ibus_cmd_addr = pc_q;
   assign accept        = ibus_cmd_en && ibus_cmd_ready;

   assign instr_valid = !fifo_empty && !redirect_valid;
   assign instr       = fifo_empty ? 32'h0 : fifo_rdata;
   assign pop         = instr_valid && instr_ready;
   assign push        = rsp_ok && (discard_q == '0) && !redirect_valid;

   always_comb begin
      pc_d      = pc_q;
      out_d     = out_q + c_CNT_W'(accept) - c_CNT_W'(rsp_ok);
      discard_d = discard_q;
      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old
         // stream; no command is accepted during a redirect.
         pc_d      = word_align(redirect_pc);
         discard_d = out_q - c_CNT_W'(rsp_ok);
      end else begin
         if (accept)
            pc_d = pc_q + 32'(INSTR_BYTES);
         if (rsp_ok && (discard_q != '0))
            discard_d = discard_q - c_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc_q      <= RESET_PC;
         out_q     <= '0;
         discard_q <= '0;
      end else begin
         pc_q      <= pc_d;
         out_q     <= out_d;
         discard_q <= discard_d;
      end
   end

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_ibuf (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (push),
      .wdata_i (ibus_rsp_rdata),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

`ifndef SYNTHESIS
   a_rsp_has_credit: assert property (@(posedge clk) disable iff (!rstn)
      ibus_rsp_valid |-> (out_q != '0));
   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
      push |-> (!fifo_full || pop));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_unit
// Purpose : Self-checking bench for fetch_unit (RESET_PC = 0xFFFF_FFF8 so the
//           address wrap is exercised straight out of reset). A queue-based
//           bus responder and an abstract fetch model run every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam logic [31:0] RP    = 32'hFFFF_FFF8;
   localparam int          DEPTH = 4;
   localparam int          MAXO  = 2;

   logic        clk = 1'b0;
   logic        rstn, instr_ready, redirect_valid, ibus_cmd_ready, ibus_rsp_valid;
   logic [31:0] redirect_pc, ibus_rsp_rdata, instr, ibus_cmd_addr;
   logic        instr_valid, ibus_cmd_en;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RP), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rstn(rstn), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .ibus_cmd_addr(ibus_cmd_addr),
      .ibus_cmd_en(ibus_cmd_en), .ibus_cmd_ready(ibus_cmd_ready),
      .ibus_rsp_rdata(ibus_rsp_rdata), .ibus_rsp_valid(ibus_rsp_valid));

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   int n_chk = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Bus responder: accepted reads answered in order after their latency.
   typedef struct { logic [31:0] addr; int due; } pend_t;
   pend_t pend[$];
   // Abstract model: in-flight reads tagged keep/drop, FIFO as a word queue.
   typedef struct { logic [31:0] addr; bit drop; } fly_t;
   fly_t        m_fly[$];
   logic [31:0] m_fifo[$];
   logic [31:0] m_pc;
   bit          m_on = 0;
   int          cyc = 0, lat = 1;
   bit          rand_lat = 0;
   // Observations taken just before the most recent edge.
   logic        s_en, s_valid, s_acc, s_pop;
   logic [31:0] s_addr, s_instr;

   task automatic drive(input logic rs, cr, ir, rv, input logic [31:0] rpc);
      rstn = rs; ibus_cmd_ready = cr; instr_ready = ir;
      redirect_valid = rv; redirect_pc = rpc;
   endtask

   task automatic tick();
      bit e_en, e_valid, rsp;
      logic [31:0] e_instr;
      e_en = 0; e_valid = 0; e_instr = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         ibus_rsp_valid = 1'b1; ibus_rsp_rdata = mem(pend[0].addr);
      end else begin
         ibus_rsp_valid = 1'b0; ibus_rsp_rdata = $urandom;
      end
      #1;
      s_en = ibus_cmd_en; s_addr = ibus_cmd_addr; s_valid = instr_valid; s_instr = instr;
      s_acc = s_en && ibus_cmd_ready; s_pop = s_valid && instr_ready;
      if (m_on) begin
         e_en    = rstn && !redirect_valid && (m_fly.size() < MAXO) &&
                   (m_fifo.size() + m_fly.size() < DEPTH);
         e_valid = (m_fifo.size() > 0) && !redirect_valid;
         e_instr = (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
         check("model cmd_en", 32'(s_en), 32'(e_en));
         check("model cmd_addr", s_addr, m_pc);
         check("model instr_valid", 32'(s_valid), 32'(e_valid));
         check("model instr", s_instr, e_instr);
      end
      @(posedge clk); #1;
      cyc++;
      if (!rstn) pend.delete();
      else begin
         if (ibus_rsp_valid) void'(pend.pop_front());
         if (s_acc) pend.push_back('{s_addr, cyc - 1 + (rand_lat ? int'($urandom_range(1, 4)) : lat)});
      end
      if (!rstn) begin
         m_on = 1; m_pc = RP; m_fly.delete(); m_fifo.delete();
      end else if (m_on) begin
         rsp = ibus_rsp_valid && (m_fly.size() > 0);
         if (e_valid && instr_ready) void'(m_fifo.pop_front());
         if (rsp) begin
            fly_t h;
            h = m_fly.pop_front();
            if (!h.drop && !redirect_valid) m_fifo.push_back(mem(h.addr));
         end
         if (redirect_valid) begin
            m_fifo.delete();
            foreach (m_fly[i]) m_fly[i].drop = 1'b1;
            m_pc = redirect_pc & ~32'h3;
         end else if (e_en && ibus_cmd_ready) begin
            m_fly.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   typedef struct {
      logic rs, cr, ir, rv; logic [31:0] rpc;
      logic en; logic [31:0] addr; logic valid; logic [31:0] ins;
   } vec_t;
   vec_t vt[10];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] got[$];
      int nacc, first_acc;
      bit seen;

      // Reset wrap, steady stream, and redirect coinciding with a response
      // while instr_ready is high (1-cycle bus latency).
      vt[0] = '{0,1,1,0,32'h0,   0, RP,          0, 32'h0};
      vt[1] = '{1,1,1,0,32'h0,   1, RP,          0, 32'h0};
      vt[2] = '{1,1,1,0,32'h0,   1, 32'hFFFF_FFFC, 0, 32'h0};
      vt[3] = '{1,1,1,0,32'h0,   1, 32'h0,       1, mem(RP)};
      vt[4] = '{1,1,1,0,32'h0,   1, 32'h4,       1, mem(32'hFFFF_FFFC)};
      vt[5] = '{1,1,1,0,32'h0,   1, 32'h8,       1, mem(32'h0)};
      vt[6] = '{1,1,1,1,32'h103, 0, 32'hC,       0, mem(32'h4)};
      vt[7] = '{1,1,1,0,32'h0,   1, 32'h100,     0, 32'h0};
      vt[8] = '{1,1,1,0,32'h0,   1, 32'h104,     0, 32'h0};
      vt[9] = '{1,1,1,0,32'h0,   1, 32'h108,     1, mem(32'h100)};

      drive(0, 1, 1, 0, 32'h0);
      tick(); tick();
      for (int i = 0; i < 10; i++) begin
         drive(vt[i].rs, vt[i].cr, vt[i].ir, vt[i].rv, vt[i].rpc);
         tick();
         check($sformatf("vec%0d cmd_en", i), 32'(s_en), 32'(vt[i].en));
         check($sformatf("vec%0d cmd_addr", i), s_addr, vt[i].addr);
         check($sformatf("vec%0d instr_valid", i), 32'(s_valid), 32'(vt[i].valid));
         check($sformatf("vec%0d instr", i), s_instr, vt[i].ins);
      end

      // FIFO fill with consumer stalled: exactly four reads, then drain.
      drive(1, 1, 0, 1, 32'h0); tick();
      drive(1, 1, 0, 0, 32'h0);
      got.delete();
      for (int i = 0; i < 8; i++) begin
         tick();
         if (s_acc) got.push_back(s_addr);
      end
      check("fill read count", got.size(), 4);
      for (int k = 0; k < 4 && k < got.size(); k++)
         check($sformatf("fill addr%0d", k), got[k], 32'(4 * k));
      check("fill cmd_en low", 32'(s_en), 32'h0);
      drive(1, 1, 1, 0, 32'h0);
      got.delete(); first_acc = -1;
      for (int i = 0; i < 12 && (got.size() < 4 || first_acc < 0); i++) begin
         tick();
         if (s_pop) got.push_back(s_instr);
         if (s_acc && first_acc < 0) first_acc = int'(s_addr);
      end
      check("drain count", got.size(), 4);
      for (int k = 0; k < 4 && k < got.size(); k++)
         check($sformatf("drain word%0d", k), got[k], mem(32'(4 * k)));
      check("resume addr", 32'(first_acc), 32'h10);

      // Command channel stall: request and address held, PC frozen.
      drive(1, 1, 1, 1, 32'h300); tick();
      drive(1, 0, 1, 0, 32'h0); tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall cmd_en", 32'(s_en), 32'h1);
         check("stall cmd_addr", s_addr, 32'h300);
      end
      drive(1, 1, 1, 0, 32'h0); tick();
      check("stall release accept", 32'(s_acc), 32'h1);
      tick();
      check("stall next addr", s_addr, 32'h304);

      // Redirect with two reads in flight (3-cycle latency).
      lat = 3;
      for (int i = 0; i < 6; i++) tick();
      check("outstanding before redirect", m_fly.size(), 2);
      drive(1, 1, 1, 1, 32'h103); tick();
      check("redirect cmd_en", 32'(s_en), 32'h0);
      check("redirect instr_valid", 32'(s_valid), 32'h0);
      drive(1, 1, 1, 0, 32'h0);
      seen = 0; first_acc = -1;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (s_acc && first_acc < 0) first_acc = int'(s_addr);
         if (s_pop) begin seen = 1; check("first instr after redirect", s_instr, mem(32'h100)); end
      end
      check("redirect first addr", 32'(first_acc), 32'h100);
      check("redirect delivered", 32'(seen), 32'h1);

      // Reset with reads in flight: restart at RESET_PC, nothing stale.
      for (int i = 0; i < 3; i++) tick();
      drive(0, 1, 1, 0, 32'h0); tick();
      drive(1, 1, 1, 0, 32'h0); tick();
      check("post-reset addr", s_addr, RP);
      check("post-reset instr_valid", 32'(s_valid), 32'h0);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (s_pop) begin seen = 1; check("post-reset first instr", s_instr, mem(RP)); end
      end
      check("post-reset delivered", 32'(seen), 32'h1);

      // Random traffic against the model.
      rand_lat = 1;
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom);
         tick();
      end
      drive(1, 1, 1, 0, 32'h0);
      for (int i = 0; i < 10; i++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
